sram_mem_ctrl: RTL
==================

// Module: sram_mem_ctrl
// PURPOSE
//  Memory access controller downstream of the LC-3 datapath: consumes MAR/MDR and a read/write request from the ISDU.
//  Runs one handshaked access to the async 16-bit SRAM and returns read data on MDR_In for the datapath MDR mux.
//  Sole owner of SRAM strobes and of the SRAM data-bus tristate.
// PARAMETERS
//  WAIT_CYCLES  2   cycles strobes (OE_N or WE_N) stay asserted per access; legal range 1..15
//  ADDR_W       20  SRAM address width; MAR is zero-extended into it
// PORTS
//  Clk         in     1       system clock, all state on rising edge
//  Reset_n     in     1       asynchronous, active-low reset
//  Req         in     1       access request (level), sampled only in IDLE
//  Wr          in     1       1=write, 0=read; sampled with Req
//  MAR         in     16      access address
//  MDR         in     16      write data
//  MDR_In      out    16      last read data, to datapath MDR mux
//  Ready       out    1       one-cycle pulse: access complete, MDR_In valid for reads
//  Busy        out    1       high in every state except IDLE
//  SRAM_ADDR   out    ADDR_W  SRAM address
//  SRAM_CE_N   out    1       chip enable, active low
//  SRAM_OE_N   out    1       output enable, active low
//  SRAM_WE_N   out    1       write enable, active low
//  SRAM_UB_N   out    1       upper byte enable, active low
//  SRAM_LB_N   out    1       lower byte enable, active low
//  SRAM_DQ     inout  16      SRAM data bus
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; MDR_In=0; Ready=0; Busy=0; SRAM_ADDR=0.
//    All strobes 1; SRAM_DQ high-Z.
//  - Reset mid-access aborts at once: strobes deassert and DQ releases without waiting for a clock edge.
//  - States: IDLE, RD_ACC, WR_SETUP, WR_ACC, WR_HOLD, DONE, WAIT_REL.
//  - IDLE: on an edge with Req=1 and the re-arm flag set, latch {MAR,MDR,Wr}.
//    Go to RD_ACC (Wr=0) or WR_SETUP (Wr=1).
//  - Re-arm flag: cleared at acceptance; set when Req=0 is seen.
//    Req held high across several ISDU states therefore yields exactly one access.
//  - RD_ACC: CE_N=OE_N=UB_N=LB_N=0 for WAIT_CYCLES cycles; wait counter counts down.
//    On the last cycle's edge, MDR_In <= SRAM_DQ; go to DONE.
//  - WR_SETUP, 1 cycle: CE_N/UB_N/LB_N=0; WE_N=1; DQ driven with latched MDR.
//  - WR_ACC: WE_N=0 for WAIT_CYCLES cycles; DQ driven.
//  - WR_HOLD, 1 cycle: WE_N=1; CE_N=0; DQ still driven (data hold); then DONE.
//  - DQ is driven only in WR_SETUP, WR_ACC and WR_HOLD; high-Z in every other state.
//  - OE_N and WE_N are never 0 in the same cycle.
//  - DONE, 1 cycle: Ready=1; strobes inactive.
//    Next state is IDLE if Req=0, else WAIT_REL.
//  - WAIT_REL: hold until Req=0, then IDLE; Busy=1 throughout.
//  - Latency, Req accepted at edge k:
//    read Ready high in cycle k+WAIT_CYCLES+1;
//    write Ready high in cycle k+WAIT_CYCLES+3.
//  - Min request-to-request spacing with Req dropped at Ready: read W+2 cycles, write W+4.
//  - Inputs are ignored outside IDLE: Req falling, MAR or MDR changing mid-access have no effect.
//    The latched values are used to completion.
//  - SRAM_ADDR = {{(ADDR_W-16){1'b0}}, latched MAR}; holds its value after the access.
//  - MDR_In changes only at read capture; writes leave it unchanged.
//  - Wait counter: $clog2(WAIT_CYCLES+1) bits, loaded with WAIT_CYCLES-1 at entry to RD_ACC/WR_ACC.
//    Exit when it reaches 0; no wrap.
//  - Elaboration assertion: WAIT_CYCLES >= 1.
// STRUCTURE
//  - lc3_pkg: typedef enum logic [2:0] mem_state_t; constant MEM_WAIT_MAX=15.
//  - Sub-module tristate #(.N(16)): drives SRAM_DQ from the latched MDR under an output-enable.
//    Also presents the bus value for read capture.
//  - Everything else (FSM, wait counter, latches, re-arm flag) stays in this file; outputs are registered or state-decoded.
// TESTING
//  - Reset: Reset_n=0 mid-WR_ACC
//    -> same cycle WE_N=1, CE_N=1, DQ=Z; after release Busy=0, MDR_In=0.
//  - Read, W=2: SRAM model returns 16'hBEEF at addr 16'h3000; Req=1, Wr=0, MAR=16'h3000 at edge 0
//    -> OE_N=0 in cycles 1-2; SRAM_ADDR=20'h03000; Ready in cycle 3; MDR_In=16'hBEEF.
//  - Write, W=2: MAR=16'h0010, MDR=16'h1234
//    -> DQ=16'h1234 in cycles 1-4; WE_N=0 only in cycles 2-3; Ready in cycle 5.
//    A follow-up read of 16'h0010 returns 16'h1234.
//  - Held Req: Req high for 10 cycles
//    -> exactly one access and one Ready pulse.
//    Req low 1 cycle, then high -> a second access starts.
//  - Mid-access input change: MAR/MDR/Wr switched in cycle 1 of a write
//    -> the SRAM sees the original address and data; no read strobes.
//  - WAIT_CYCLES=1 build: read Ready at cycle 2, write Ready at cycle 4; OE_N and WE_N never both 0 (assertion).

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared types for the LC-3 memory controller: access FSM encoding and wait-state limit.
package lc3_pkg;

  localparam int unsigned MEM_WAIT_MAX = 15;

  typedef enum logic [2:0] {
    StIdle,
    StRdAcc,
    StWrSetup,
    StWrAcc,
    StWrHold,
    StDone,
    StWaitRel
  } mem_state_t;

endpackage

// File: rtl/tristate.sv
// Bidirectional bus buffer: drives the bus under an output-enable and always
// presents the resolved bus value for capture.
module tristate #(
  parameter int unsigned N = 16
) (
  input  logic         oe_i,
  input  logic [N-1:0] data_i,
  output logic [N-1:0] data_o,
  inout  wire  [N-1:0] bus_io
);

  assign bus_io = oe_i ? data_i : {N{1'bz}};
  assign data_o = bus_io;

endmodule

// File: rtl/sram_mem_ctrl.sv
// Single-access handshaked controller for an async 16-bit SRAM behind the LC-3 MAR/MDR.
// Owns all SRAM strobes and the data-bus tristate; returns read data on MDR_In.
module sram_mem_ctrl
  import lc3_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 20
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Req,
  input  logic              Wr,
  input  logic [15:0]       MAR,
  input  logic [15:0]       MDR,
  output logic [15:0]       MDR_In,
  output logic              Ready,
  output logic              Busy,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  inout  wire  [15:0]       SRAM_DQ
);

  localparam int unsigned CntW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_CYCLES - 1);

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > MEM_WAIT_MAX) begin : g_bad_wait
      $error("sram_mem_ctrl: WAIT_CYCLES must be in 1..15");
    end
    if (ADDR_W < 16) begin : g_bad_addr
      $error("sram_mem_ctrl: ADDR_W must be at least 16");
    end
  endgenerate

  mem_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [15:0]     mdr_in_q, mdr_in_d;
  logic            arm_q, arm_d;
  logic            dq_oe;
  logic [15:0]     dq_in;

  tristate #(
    .N(16)
  ) u_dq_buf (
    .oe_i  (dq_oe),
    .data_i(wdata_q),
    .data_o(dq_in),
    .bus_io(SRAM_DQ)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mdr_in_q <= '0;
      arm_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mdr_in_q <= mdr_in_d;
      arm_q    <= arm_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mdr_in_d = mdr_in_q;
    // A low Req anywhere re-arms; a level held across ISDU states yields one access.
    arm_d    = arm_q | ~Req;
    unique case (state_q)
      StIdle: begin
        if (Req && arm_q) begin
          addr_d  = MAR;
          wdata_d = MDR;
          arm_d   = 1'b0;
          if (Wr) begin
            state_d = StWrSetup;
          end else begin
            state_d = StRdAcc;
            cnt_d   = CntLoad;
          end
        end
      end
      StRdAcc: begin
        if (cnt_q == '0) begin
          mdr_in_d = dq_in;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWrSetup: begin
        state_d = StWrAcc;
        cnt_d   = CntLoad;
      end
      StWrAcc: begin
        if (cnt_q == '0) begin
          state_d = StWrHold;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWrHold:  state_d = StDone;
      StDone:    state_d = Req ? StWaitRel : StIdle;
      StWaitRel: if (!Req) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Strobes decode straight from state so an async reset releases them immediately.
  always_comb begin
    Ready     = 1'b0;
    Busy      = 1'b1;
    SRAM_CE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    unique case (state_q)
      StIdle:  Busy = 1'b0;
      StRdAcc: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
      end
      StWrSetup, StWrHold: begin
        SRAM_CE_N = 1'b0;
        dq_oe     = 1'b1;
      end
      StWrAcc: begin
        SRAM_CE_N = 1'b0;
        SRAM_WE_N = 1'b0;
        dq_oe     = 1'b1;
      end
      StDone:    Ready = 1'b1;
      StWaitRel: ;
      default:   Busy = 1'b1;
    endcase
  end

  assign SRAM_UB_N = SRAM_CE_N;
  assign SRAM_LB_N = SRAM_CE_N;
  assign SRAM_ADDR = ADDR_W'(addr_q);
  assign MDR_In    = mdr_in_q;

endmodule
